// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared types and constants for the L1 cache memory responder
package cache_mem_pkg;

   localparam int         LINE_WORDS_DEF = 4;
   localparam logic [3:0] TYPE_NONE      = 4'hf;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_DRAIN,
      ST_WR_ISSUE,
      ST_WR_NOP
   } state_e;

endpackage

// File: rtl/l1c_mem_responder.sv
// rtl/l1c_mem_responder.sv - L1 cache request responder: line-fill read bursts and masked single-word writes
module l1c_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              I_req,
   input  logic [ADDR_W-1:0] I_addr,
   input  logic              I_write,
   input  logic [DATA_W-1:0] I_in,
   input  logic [3:0]        I_type,
   output logic [DATA_W-1:0] I_out,
   output logic              I_valid,
   output logic              I_wait,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_web,
   output logic [DATA_W-1:0] mem_di,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_do,
   output logic [31:0]       rd_cnt,
   output logic [31:0]       wr_cnt
);

   localparam int               IDX_W    = $clog2(LINE_WORDS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:2]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [3:0]          type_q, type_d;
   logic [IDX_W-1:0]    issue_q, issue_d;
   logic [IDX_W-1:0]    ret_q, ret_d;
   logic                wait_q, wait_d;
   logic [31:0]         rd_cnt_q, rd_cnt_d;
   logic [31:0]         wr_cnt_q, wr_cnt_d;

   // Memory is word addressed; the byte offset of a request never reaches the port.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^I_addr[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         type_q   <= TYPE_NONE;
         issue_q  <= '0;
         ret_q    <= '0;
         wait_q   <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         type_q   <= type_d;
         issue_q  <= issue_d;
         ret_q    <= ret_d;
         wait_q   <= wait_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      type_d   = type_q;
      issue_d  = issue_q;
      ret_d    = ret_q;
      wait_d   = wait_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      mem_req  = 1'b0;
      mem_addr = '0;
      mem_web  = TYPE_NONE;
      mem_di   = '0;
      I_valid  = 1'b0;
      I_out    = '0;

      case (state_q)
         ST_IDLE: begin
            if (I_req) begin
               addr_d  = I_addr[ADDR_W-1:2];
               data_d  = I_in;
               type_d  = I_type;
               issue_d = '0;
               ret_d   = '0;
               wait_d  = 1'b1;
               if (!I_write)
                  state_d = ST_RD_ISSUE;
               else if (I_type == TYPE_NONE)
                  state_d = ST_WR_NOP;
               else
                  state_d = ST_WR_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:IDX_W+2], issue_q, 2'b00};
            if (mem_gnt) begin
               issue_d = issue_q + IDX_ONE;
               if (issue_q == IDX_LAST)
                  state_d = ST_RD_DRAIN;
            end
         end
         ST_RD_DRAIN: begin
         end
         ST_WR_ISSUE: begin
            mem_req  = 1'b1;
            mem_addr = {addr_q, 2'b00};
            mem_web  = type_q;
            mem_di   = data_q;
            if (mem_gnt) begin
               state_d  = ST_IDLE;
               wait_d   = 1'b0;
               wr_cnt_d = wr_cnt_q + 32'd1;
            end
         end
         ST_WR_NOP: begin
            state_d  = ST_IDLE;
            wait_d   = 1'b0;
            wr_cnt_d = wr_cnt_q + 32'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Return beats pass straight through; the final beat overrides any issue-side transition.
      if (state_q == ST_RD_ISSUE || state_q == ST_RD_DRAIN) begin
         I_valid = mem_rvalid;
         I_out   = mem_do;
         if (mem_rvalid) begin
            ret_d = ret_q + IDX_ONE;
            if (ret_q == IDX_LAST) begin
               state_d  = ST_IDLE;
               wait_d   = 1'b0;
               rd_cnt_d = rd_cnt_q + 32'd1;
            end
         end
      end
   end

   assign I_wait = wait_q;
   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;

endmodule
